// File: rtl/afifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : afifo_pkg                                              |
// | Description : Shared types and constants for the async-FIFO read-    |
// |               side stream adapter (afifo_rd_stream, afifo_skid_buf). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package afifo_pkg;

  // Default FIFO word width
  localparam int DEF_DATA_WIDTH = 32;

  // Number of entries in the prefetch buffer
  localparam int BUF_DEPTH = 2;

  // Width of the statistics counters
  localparam int STAT_W = 32;

  // Buffer occupancy, 0..BUF_DEPTH
  typedef logic [1:0] occ_t;

  // Words still owed to the buffer once this cycle's pop has left:
  // held words plus the one in flight minus the one leaving.
  function automatic logic [2:0] occ_after(occ_t occ, logic infl, logic pop);
    return {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  endfunction

endpackage : afifo_pkg
`default_nettype wire

// File: rtl/afifo_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : afifo_skid_buf                                         |
// | Description : Two-entry ordered register buffer. Entry 0 is the      |
// |               head. A pop shifts entry 1 forward; a push lands at    |
// |               index (occ - pop). Flush empties it and wins over      |
// |               push and pop. Valid is a dedicated flop.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module afifo_skid_buf
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output occ_t                  occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  occ_t                  r_occ;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_ent0;
  logic [DATA_WIDTH-1:0] r_ent1;

  occ_t                  w_occ_nxt;
  occ_t                  w_wr_idx;
  logic [DATA_WIDTH-1:0] w_ent0_nxt;
  logic [DATA_WIDTH-1:0] w_ent1_nxt;

  // Next buffer contents: shift on pop, then write behind whatever remains
  always_comb begin
    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    w_occ_nxt  = r_occ;
    w_wr_idx   = r_occ - {1'b0, pop};
    if (flush) begin
      w_occ_nxt = '0;
    end else begin
      if (pop) begin
        w_ent0_nxt = r_ent1;
      end
      if (push) begin
        if (w_wr_idx == 2'd0) begin
          w_ent0_nxt = push_data;
        end else begin
          w_ent1_nxt = push_data;
        end
      end
      w_occ_nxt = r_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer state registers; valid is registered so the output has no
  // combinational path from the incoming word
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= '0;
      r_valid <= 1'b0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
      r_ent0  <= w_ent0_nxt;
      r_ent1  <= w_ent1_nxt;
    end
  end

  assign occ   = r_occ;
  assign valid = r_valid;
  assign head  = r_ent0;

endmodule : afifo_skid_buf
`default_nettype wire

// File: rtl/afifo_rd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : afifo_rd_stream                                        |
// | Description : Converts the async FIFO read port (rd_en/empty, data   |
// |               one cycle after the pop) into a registered valid/ready |
// |               stream using a 2-entry prefetch buffer. Sustains one   |
// |               beat per cycle with full backpressure.                 |
// |               Optional macro AFIFO_RD_STATS_EN enables the beat and  |
// |               stall counters; otherwise both ports read zero.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [STAT_W-1:0]     beat_cnt,
  output logic [STAT_W-1:0]     stall_cnt
);

  occ_t w_occ;
  logic r_infl;
  logic w_pop;
  logic w_push;

  // A beat leaves only when the stream handshakes; flush discards it
  assign w_pop  = m_valid && m_ready;

  // The word returning from last cycle's pop is captured unless flushed
  assign w_push = r_infl && !flush;

  // Prefetch only while the buffer has room for everything already owed.
  // Gated by rst_n so no pop is requested while reset is held.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      (occ_after(w_occ, r_infl, w_pop) < 3'(BUF_DEPTH));

  // In-flight flag: a pop this cycle means data arrives next cycle
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl <= 1'b0;
    end else begin
      r_infl <= fifo_rd_en;
    end
  end

  afifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (fifo_rd_data),
    .pop       (w_pop && !flush),
    .flush     (flush),
    .occ       (w_occ),
    .valid     (m_valid),
    .head      (m_data)
  );

`ifdef AFIFO_RD_STATS_EN
  logic [STAT_W-1:0] r_beat_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  // Free-running statistics, cleared only by reset; beats lost to a
  // flush are not counted
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && !flush) begin
        r_beat_cnt <= r_beat_cnt + STAT_W'(1);
      end
      if (m_valid && !m_ready) begin
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule : afifo_rd_stream
`default_nettype wire

// File: tb/tb_afifo_rd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_afifo_rd_stream                                     |
// | Description : Self-checking bench for afifo_rd_stream. A queue-based |
// |               FIFO model feeds the DUT; a scoreboard of words owed   |
// |               (with the cycle each was popped) predicts m_valid,     |
// |               m_data, ordering and counters. AFIFO_RD_STATS_EN       |
// |               selects the expected counter behaviour.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_afifo_rd_stream;

  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;

  always #5 rd_clk = ~rd_clk;

  afifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .beat_cnt     (beat_cnt),
    .stall_cnt    (stall_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int now      = 0;
  bit gap      = 1'b0;

  logic [DW-1:0] fq[$];     // words still inside the upstream FIFO
  logic [DW-1:0] exp_d[$];  // words popped and owed to the stream, in order
  int            exp_c[$];  // cycle in which each owed word was popped
  logic [DW-1:0] dlog[$];   // delivered words
  int            dcyc[$];   // delivery cycles

  logic [31:0] exp_beat  = '0;
  logic [31:0] exp_stall = '0;

  logic          s_en, s_v, s_r, s_f;
  logic [DW-1:0] s_d;
  bit            hold = 1'b0;
  logic [DW-1:0] hold_d = '0;

  // One clock cycle: sample on the falling edge, update the models,
  // then present the FIFO response just after the rising edge.
  task automatic step();
    logic [DW-1:0] w;
    bit ev;
    w = $urandom;
    fifo_empty = gap || (fq.size() == 0);
    @(negedge rd_clk);
    s_en = fifo_rd_en; s_v = m_valid; s_r = m_ready; s_f = flush; s_d = m_data;
    ev = (exp_d.size() > 0) && (exp_c[0] + 2 <= now);
    checks++;
    if (s_v !== ev) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%0b exp=%0b", now, s_v, ev);
    end
    if (ev) begin
      checks++;
      if (s_d !== exp_d[0]) begin
        failures++;
        $display("FAIL m_data cyc=%0d got=%h exp=%h", now, s_d, exp_d[0]);
      end
    end
    if (hold) begin
      checks++;
      if (s_v !== 1'b1 || s_d !== hold_d) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%0b d=%h exp v=1 d=%h", now, s_v, s_d, hold_d);
      end
    end
    checks++;
    if (s_en && fifo_empty) begin
      failures++;
      $display("FAIL rd_en_when_empty cyc=%0d got=1 exp=0", now);
    end
    if (s_f) begin
      exp_d.delete(); exp_c.delete(); hold = 1'b0;
    end else begin
      if (s_v && s_r) begin
        if (exp_d.size() > 0) begin
          void'(exp_d.pop_front()); void'(exp_c.pop_front());
        end
        dlog.push_back(s_d); dcyc.push_back(now);
`ifdef AFIFO_RD_STATS_EN
        exp_beat = exp_beat + 1;
`endif
      end
      hold = s_v && !s_r; hold_d = s_d;
    end
`ifdef AFIFO_RD_STATS_EN
    if (s_v && !s_r) exp_stall = exp_stall + 1;
`endif
    if (s_en) begin
      if (fq.size() > 0) w = fq.pop_front();
      exp_d.push_back(w); exp_c.push_back(now);
    end
    checks++;
    if (exp_d.size() > 2) begin
      failures++;
      $display("FAIL occupancy cyc=%0d got=%0d exp<=2", now, exp_d.size());
    end
    @(posedge rd_clk);
    #1;
    checks++;
    if (beat_cnt !== exp_beat) begin
      failures++;
      $display("FAIL beat_cnt cyc=%0d got=%0d exp=%0d", now, beat_cnt, exp_beat);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", now, stall_cnt, exp_stall);
    end
    fifo_rd_data = s_en ? w : DW'($urandom);
    now++;
  endtask

  // Assert reset away from a clock edge and check outputs clear at once
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || m_data !== '0 ||
        beat_cnt !== '0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b en=%0b d=%h beat=%0d stall=%0d exp all 0",
               m_valid, fifo_rd_en, m_data, beat_cnt, stall_cnt);
    end
    exp_d.delete(); exp_c.delete(); hold = 1'b0;
    exp_beat = '0; exp_stall = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Let everything owed reach the output
  task automatic drain();
    int n;
    m_ready = 1'b1; gap = 1'b0; flush = 1'b0;
    n = 0;
    while ((fq.size() > 0 || exp_d.size() > 0) && n < 100) begin
      step(); n++;
    end
    checks++;
    if (fq.size() > 0 || exp_d.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout got fifo=%0d owed=%0d exp 0", fq.size(), exp_d.size());
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(32'h100 + i));
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (s_v !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill got m_valid=%0b exp=1", s_v);
    end
    do_reset();
    fq.delete();
    m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_v) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL reset_stale_word got=%0d beats exp=0", n);
    end
  endtask

  task automatic test_streaming();
    int first_en;
    int n;
    logic [31:0] b0;
    drain();
    b0 = exp_beat;
    dlog.delete(); dcyc.delete();
    for (int i = 1; i <= 16; i++) fq.push_back(DW'(i));
    m_ready = 1'b1;
    first_en = -1;
    n = 0;
    while (dlog.size() < 16 && n < 60) begin
      step(); n++;
      if (s_en && first_en < 0) first_en = now - 1;
    end
    checks++;
    if (dlog.size() != 16) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=16", dlog.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (dlog[i] !== DW'(i + 1)) begin
          failures++;
          $display("FAIL stream_order idx=%0d got=%h exp=%h", i, dlog[i], i + 1);
        end
      end
      checks++;
      if (dcyc[0] != first_en + 2 || dcyc[15] != dcyc[0] + 15) begin
        failures++;
        $display("FAIL stream_timing got first=%0d last=%0d exp first=%0d last=%0d",
                 dcyc[0], dcyc[15], first_en + 2, first_en + 17);
      end
    end
`ifdef AFIFO_RD_STATS_EN
    checks++;
    if (beat_cnt !== b0 + 32'd16) begin
      failures++;
      $display("FAIL stream_beats got=%0d exp=%0d", beat_cnt, b0 + 32'd16);
    end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] st0;
    drain();
    st0 = exp_stall;
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) fq.push_back(DW'(i));
    n = 0;
    s_v = 1'b0;
    while (!s_v && n < 10) begin
      step(); n++;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_d !== DW'(1)) begin
        failures++;
        $display("FAIL bp_hold_data got=%h exp=1", s_d);
      end
    end
    checks++;
    if (s_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_prefetch_stop got rd_en=%0b exp=0", s_en);
    end
`ifdef AFIFO_RD_STATS_EN
    checks++;
    if (stall_cnt !== st0 + 32'd5) begin
      failures++;
      $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, st0 + 32'd5);
    end
`endif
    dlog.delete(); dcyc.delete();
    m_ready = 1'b1;
    n = 0;
    while (dlog.size() < 3 && n < 10) begin
      step(); n++;
    end
    checks++;
    if (dlog.size() != 3 || dlog[0] !== DW'(1) || dlog[1] !== DW'(2) || dlog[2] !== DW'(3) ||
        dcyc[1] != dcyc[0] + 1 || dcyc[2] != dcyc[0] + 2) begin
      failures++;
      $display("FAIL bp_release got %0d beats exp 1,2,3 back-to-back", dlog.size());
    end
  endtask

  task automatic test_empty_gap();
    int n;
    int low;
    drain();
    dlog.delete(); dcyc.delete();
    m_ready = 1'b1;
    fq.push_back(DW'(32'hA)); fq.push_back(DW'(32'hB));
    n = 0;
    while (fq.size() > 0 && n < 10) begin
      step(); n++;
    end
    gap = 1'b1;
    fq.push_back(DW'(32'hC)); fq.push_back(DW'(32'hD));
    low = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i >= 2 && !s_v) low++;
    end
    checks++;
    if (low != 2) begin
      failures++;
      $display("FAIL gap_valid_low got=%0d low cycles exp=2", low);
    end
    gap = 1'b0;
    n = 0;
    while (dlog.size() < 4 && n < 20) begin
      step(); n++;
    end
    checks++;
    if (dlog.size() != 4 || dlog[0] !== DW'(32'hA) || dlog[1] !== DW'(32'hB) ||
        dlog[2] !== DW'(32'hC) || dlog[3] !== DW'(32'hD)) begin
      failures++;
      $display("FAIL gap_order got %0d beats exp A,B,C,D", dlog.size());
    end
  endtask

  task automatic test_flush();
    int n;
    drain();
    dlog.delete(); dcyc.delete();
    m_ready = 1'b1;
    fq.push_back(DW'(32'h21)); fq.push_back(DW'(32'h22)); fq.push_back(DW'(32'h23));
    n = 0;
    s_en = 1'b0;
    while (!s_en && n < 10) begin
      step(); n++;
    end
    step();
    flush = 1'b1;
    step();
    checks++;
    if (s_v !== 1'b1 || s_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got v=%0b en=%0b exp v=1 en=0", s_v, s_en);
    end
    flush = 1'b0;
    step();
    checks++;
    if (s_v !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got m_valid=%0b exp=0", s_v);
    end
    dlog.delete(); dcyc.delete();
    n = 0;
    while (dlog.size() < 1 && n < 10) begin
      step(); n++;
    end
    checks++;
    if (dlog.size() != 1 || dlog[0] !== DW'(32'h23)) begin
      failures++;
      $display("FAIL flush_next_word got n=%0d d=%h exp 23", dlog.size(),
               (dlog.size() > 0) ? dlog[0] : '0);
    end
  endtask

  task automatic test_random();
    int n;
    drain();
    for (int i = 0; i < 1000; i++) fq.push_back(DW'($urandom));
    n = 0;
    while ((fq.size() > 0 || exp_d.size() > 0) && n < 20000) begin
      m_ready = 1'($urandom_range(1, 0));
      gap     = ($urandom_range(3, 0) == 0);
      flush   = ($urandom_range(127, 0) == 0);
      step(); n++;
    end
    flush = 1'b0; gap = 1'b0;
    checks++;
    if (fq.size() > 0 || exp_d.size() > 0) begin
      failures++;
      $display("FAIL random_timeout got fifo=%0d owed=%0d exp 0", fq.size(), exp_d.size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    @(posedge rd_clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_gap();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_afifo_rd_stream
`default_nettype wire

// File: doc/afifo_rd_stream.md
Name: afifo_rd_stream

Overview:
Read-side adapter placed directly downstream of the team's async FIFO, in the rd_clk domain. It converts the FIFO's rd_en/empty/rd_data interface, where data arrives one cycle after the pop, into a registered valid/ready stream. A 2-entry prefetch buffer sustains one beat per cycle, gives full backpressure, and never drops or duplicates a word.

Parameters:
DATA_WIDTH, 32, width of the FIFO word and of m_data.

Ports:
rd_clk  input  1  single clock, shared with the FIFO read side
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag, rd_clk domain
fifo_rd_en  output  1  pop request to FIFO
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop
flush  input  1  synchronous drop of all buffered and in-flight words
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  output word
beat_cnt  output  32  accepted-beat counter (see Optional Feature)
stall_cnt  output  32  backpressure-cycle counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low, rst_n):
  - m_valid=0, m_data=0, fifo_rd_en=0.
  - Occupancy=0, in-flight flag=0, both counters=0.
  - Any word in flight is discarded.
- Internal state:
  - occ: 0..2, number of words held in the 2-entry buffer.
  - infl: 1 bit, set in the cycle after a pop is issued.
  - pop = m_valid && m_ready.
- Issue rule (combinational): fifo_rd_en = !fifo_empty && !flush && (occ + infl - pop < 2).
  - occ + infl never exceeds 2, so the buffer cannot overflow.
- Capture:
  - infl is set at the rd_clk edge closing any cycle with fifo_rd_en=1.
  - In the following cycle, fifo_rd_data is written into the buffer at index (occ - pop), and infl clears.
- Output:
  - m_valid = (occ != 0), driven from a register.
  - m_data = head entry.
  - Latency: pop issued in cycle t gives m_valid=1 in cycle t+2, with no combinational path from fifo_rd_data.
- Throughput: with fifo_empty=0 and m_ready=1 held, m_valid stays 1 every cycle from t+2 onward (100%).
- Backpressure: while m_valid && !m_ready, m_data and m_valid hold stable (AXI-style). Prefetch stops once occ+infl=2.
- Simultaneous capture and pop: head shifts out, captured word lands behind any remaining entry, occ unchanged. Order is strictly FIFO.
- FIFO goes empty mid-stream: no pop is issued. Buffered words still drain; m_valid drops after the last one.
- flush=1 (synchronous):
  - No pop in that cycle.
  - Next cycle: occ=0, m_valid=0.
  - A word returning from an earlier pop (infl=1) is discarded, not captured.
  - Flush has priority over pop and capture.
  - m_ready is ignored during the flush cycle: a beat presented with m_valid&&m_ready in that cycle is not counted and is lost.
- Reset mid-operation: all state clears immediately. The FIFO shares rst_n, so no stale in-flight word survives.

Optional Feature:
Macro AFIFO_RD_STATS_EN.
- Defined:
  - beat_cnt increments on each pop.
  - stall_cnt increments on each cycle with m_valid && !m_ready.
  - Both are 32-bit, wrap modulo 2^32, cleared by rst_n only (not by flush).
- Undefined: both ports remain and are tied to 0, with no counter logic.

Decomposition:
- Package afifo_pkg:
  - DATA_WIDTH default.
  - Localparam BUF_DEPTH=2.
  - Occupancy type logic [1:0].
  - Counter width constant STAT_W=32.
- One natural sub-module, afifo_skid_buf: 2-entry register buffer with push/pop/flush/occ and head output. afifo_rd_stream wraps it with the issue logic, in-flight tracking and counters.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with occ=2 -> m_valid=0, fifo_rd_en=0, beat_cnt=0 immediately; no word delivered after release until a new pop.
2. Streaming: 16 words 0x1..0x10 preloaded, m_ready=1 -> first m_valid 2 cycles after the first fifo_rd_en, then 16 consecutive valid cycles in order; beat_cnt=16 with AFIFO_RD_STATS_EN.
3. Backpressure: m_ready=0 for 5 cycles after the first beat -> m_data holds 0x1 stable, fifo_rd_en deasserts once occ+infl=2, stall_cnt=5; release -> 0x1, 0x2, 0x3 back-to-back with no loss or duplication.
4. Empty gap: FIFO holds 2 words, then fifo_empty=1 for 4 cycles, then 2 more words -> m_valid low during the gap, output order 0xA, 0xB, 0xC, 0xD.
5. Flush: flush=1 in the cycle a word is in flight with occ=1 -> m_valid=0 next cycle, in-flight word never appears; the next FIFO word appears as the first beat afterward.
6. Random m_ready (50%) with random fifo_empty over 1000 words -> scoreboard exact order match, occ+infl never >2, no fifo_rd_en while fifo_empty=1.
